// File: rtl/cpu_pkg.sv
// Shared constants and types for the MIPS core pipeline stages.
// Imported by the fetch stage and its next-PC selector.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int JIDX_W  = 26;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0]        DEFAULT_RESET_PC = 32'h0000_0000;

    // Source selected for the next program counter, highest priority last.
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_HOLD   = 2'd1,
        PC_BRANCH = 2'd2,
        PC_JUMP   = 2'd3
    } pc_sel_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc4;
        logic               valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

    function automatic logic [31:0] jump_target(input logic [3:0]        region,
                                                input logic [JIDX_W-1:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: jump > branch > stall > sequential.
// Also forms the redirect targets and flags a misaligned branch target.
module fetch_next_pc
    import cpu_pkg::*;
(
    input  logic [31:0]       pc,
    input  logic [3:0]        ifid_pc4_hi,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              stall,
    output logic [31:0]       next_pc,
    output logic              redirect,
    output logic              misalign
);

    pc_sel_e pc_sel;

    always_comb begin
        if (jump) begin
            pc_sel = PC_JUMP;
        end else if (branch_taken) begin
            pc_sel = PC_BRANCH;
        end else if (stall) begin
            pc_sel = PC_HOLD;
        end else begin
            pc_sel = PC_SEQ;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        next_pc  = pc + 32'd4;
        redirect = 1'b0;
        misalign = 1'b0;
        case (pc_sel)
            PC_JUMP: begin
                next_pc  = jump_target(ifid_pc4_hi, jump_index);
                redirect = 1'b1;
            end
            PC_BRANCH: begin
                next_pc  = {branch_target[31:2], 2'b00};
                redirect = 1'b1;
                misalign = |branch_target[1:0];
            end
            PC_HOLD: next_pc = pc;
            default: next_pc = pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, fetch counter
// and the registered misaligned-redirect pulse.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [JIDX_W-1:0]  jump_index,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [31:0]        ifid_pc4,
    output logic               ifid_valid,
    output logic [31:0]        fetch_count,
    output logic               misalign_err
);

    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        misalign_err_q, misalign_err_d;

    logic [31:0] next_pc;
    logic        redirect;
    logic        misalign;

    fetch_next_pc u_next_pc (
        .pc            (pc_q),
        .ifid_pc4_hi   (ifid_q.pc4[31:28]),
        .jump          (jump),
        .jump_index    (jump_index),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .misalign      (misalign)
    );

    always_comb begin
        pc_d           = next_pc;
        ifid_d         = ifid_q;
        fetch_count_d  = fetch_count_q;
        misalign_err_d = misalign;

        // A redirect squashes the word fetched this cycle and overrides stall.
        if (redirect || flush) begin
            ifid_d = IFID_BUBBLE;
        end else if (!stall) begin
            ifid_d        = '{instr: imem_instr, pc4: pc_q + 32'd4, valid: 1'b1};
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q           <= RESET_PC;
            ifid_q         <= IFID_BUBBLE;
            fetch_count_q  <= 32'h0;
            misalign_err_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            ifid_q         <= ifid_d;
            fetch_count_q  <= fetch_count_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign imem_addr    = pc_q;
    assign ifid_instr   = ifid_q.instr;
    assign ifid_pc4     = ifid_q.pc4;
    assign ifid_valid   = ifid_q.valid;
    assign fetch_count  = fetch_count_q;
    assign misalign_err = misalign_err_q;

endmodule
